bla_subtractor_8bit_pipe: RTL and testbench
===========================================

Name: bla_subtractor_8bit_pipe

Overview:
- Two-stage pipelined 8-bit borrow-lookahead subtractor with valid/ready handshakes on input and output.
- Computes diff = ain - bin - brw_in and returns diff, borrow-out and zero flag.
- Serves as the subtract-direction companion to the combinational 8-bit carry-lookahead adder in the Zilla datapath.
- The split cut lets the block close timing at fabric clock rates.

Parameters:
- SPLIT, 4, bit position of the pipeline cut. Stage 1 resolves bits [SPLIT-1:0]; stage 2 resolves bits [7:SPLIT]. Legal range 1..7.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept an operand beat
- ain  input  8  minuend, unsigned
- bin  input  8  subtrahend, unsigned
- brw_in  input  1  borrow-in, for chaining
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- diff  output  8  (ain - bin - brw_in) mod 256
- brw_out  output  1  1 when ain < bin + brw_in (unsigned underflow)
- zero  output  1  1 when diff == 8'h00

Behaviour:
- Reset:
  - Asserting rst_n low clears both stage valid flags immediately, without waiting for a clock edge.
  - Outputs after reset: out_valid=0, diff=8'h00, brw_out=0, zero=0, in_ready=1 once rst_n is high.
  - Internal data registers are also cleared to 0.
- Borrow-lookahead, per bit i:
  - propagate p[i] = ~(ain[i] ^ bin[i])
  - generate g[i] = ~ain[i] & bin[i]
  - b[i+1] = g[i] | (p[i] & b[i]), with b[0] = brw_in
  - diff[i] = ain[i] ^ bin[i] ^ b[i]
- Stage 1 (on input handshake in_valid & in_ready):
  - Registers low diff bits [SPLIT-1:0] and the borrow b[SPLIT].
  - Registers raw ain[7:SPLIT] and bin[7:SPLIT].
  - Sets s1_valid.
- Stage 2 (on advance):
  - Computes high diff bits using the registered borrow.
  - Registers the full diff, brw_out = b[8], and zero.
  - Sets s2_valid. out_valid = s2_valid.
- Flow control:
  - s2_adv = s1_valid & (~s2_valid | out_ready).
  - in_ready = ~s1_valid | s2_adv. This is combinational from out_ready; no combinational path exists from in_valid to in_ready.
- Latency: a result appears with out_valid exactly 2 clk cycles after its input handshake when there is no backpressure. Throughput is 1 beat per cycle.
- Backpressure:
  - While out_valid=1 and out_ready=0: diff, brw_out and zero are held stable, and stage 2 does not advance.
  - Stage 1 holds its beat. in_ready drops once stage 1 is full.
  - No beat is dropped or duplicated.
- Simultaneous events:
  - Output acceptance, stage-1 advance and new input acceptance can all occur in one cycle.
  - Ordering is strictly FIFO.
- Bubbles: s2_valid clears when out_ready=1 and no stage-1 beat is advancing. The data registers keep their last value; they are don't-care while out_valid=0.
- Reset mid-operation: all in-flight beats are discarded. After deassertion there are no spurious out_valid pulses.
- Width rules: results wrap modulo 256. brw_out is the sole underflow indicator. zero reflects the wrapped diff only, ignoring brw_out.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with in_valid=1, then release -> out_valid=0, diff=0, in_ready=1 at release. The first output appears only for beats handshaked after release.
- Basic latency: ain=8'h5A, bin=8'h23, brw_in=0, out_ready=1 -> 2 cycles later diff=8'h37, brw_out=0, zero=0.
- Cross-split borrow: ain=8'h10, bin=8'h01, brw_in=1 -> diff=8'h0E, brw_out=0. Then ain=8'h00, bin=8'h01 -> diff=8'hFF, brw_out=1. Then ain=8'h80, bin=8'h80 -> diff=8'h00, zero=1.
- Streaming: 256 back-to-back random beats with out_ready=1 -> one result per cycle, in order, all matching the reference model; in_ready stays 1 throughout.
- Backpressure: stream beats while toggling out_ready 0/1 randomly -> outputs stable while stalled, in_ready=0 when both stages are full, no loss or duplication, order preserved.
- Mid-flight reset: pulse rst_n low asynchronously between clock edges with 2 beats in flight -> out_valid drops immediately, and those beats never emerge after release.

Source files
------------

// File: rtl/bla_subtractor_8bit_pipe.sv
// Two-stage pipelined 8-bit borrow-lookahead subtractor.
// diff = ain - bin - brw_in (mod 256), with borrow-out and a zero flag.
// Stage 1 resolves bits [SPLIT-1:0] and the borrow into bit SPLIT.
// Stage 2 resolves bits [7:SPLIT] from the registered borrow.
// Legal SPLIT range is 1..7.
module bla_subtractor_8bit_pipe #(
  parameter int unsigned SPLIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] ain,
  input  logic [7:0] bin,
  input  logic       brw_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] diff,
  output logic       brw_out,
  output logic       zero
);

  localparam int unsigned W  = 8;
  localparam int unsigned LW = SPLIT;
  localparam int unsigned HW = W - SPLIT;

  // Stage 1 state
  logic          s1_valid;
  logic [LW-1:0] s1_dlo;
  logic          s1_brw;
  logic [HW-1:0] s1_ahi;
  logic [HW-1:0] s1_bhi;

  // Stage 2 state (the registered outputs)
  logic          s2_valid;

  // Handshake qualifiers
  logic          in_fire;
  logic          s2_adv;

  // Low-half lookahead terms
  logic [LW-1:0] lo_p;
  logic [LW-1:0] lo_g;
  logic [LW:0]   lo_b;
  logic [LW-1:0] lo_diff;

  // High-half lookahead terms
  logic [HW-1:0] hi_p;
  logic [HW-1:0] hi_g;
  logic [HW:0]   hi_b;
  logic [HW-1:0] hi_diff;
  logic [W-1:0]  full_diff;

  // Stage 2 may take a beat when it is empty or its beat is leaving.
  assign s2_adv    = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s2_adv;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Low-half borrow chain seeded by brw_in.
  always_comb begin
    lo_p    = ~(ain[LW-1:0] ^ bin[LW-1:0]);
    lo_g    = ~ain[LW-1:0] & bin[LW-1:0];
    lo_b    = '0;
    lo_diff = '0;
    lo_b[0] = brw_in;
    for (int i = 0; i < int'(LW); i++) begin
      lo_diff[i] = ain[i] ^ bin[i] ^ lo_b[i];
      lo_b[i+1]  = lo_g[i] | (lo_p[i] & lo_b[i]);
    end
  end

  // High-half borrow chain seeded by the registered cross-split borrow.
  always_comb begin
    hi_p    = ~(s1_ahi ^ s1_bhi);
    hi_g    = ~s1_ahi & s1_bhi;
    hi_b    = '0;
    hi_diff = '0;
    hi_b[0] = s1_brw;
    for (int i = 0; i < int'(HW); i++) begin
      hi_diff[i] = s1_ahi[i] ^ s1_bhi[i] ^ hi_b[i];
      hi_b[i+1]  = hi_g[i] | (hi_p[i] & hi_b[i]);
    end
    full_diff = {hi_diff, s1_dlo};
  end

  // Stage 1 register: low result, cross-split borrow, raw high operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_dlo   <= '0;
      s1_brw   <= 1'b0;
      s1_ahi   <= '0;
      s1_bhi   <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_dlo   <= lo_diff;
        s1_brw   <= lo_b[LW];
        s1_ahi   <= ain[W-1:LW];
        s1_bhi   <= bin[W-1:LW];
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 register: full difference, borrow-out and zero flag, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      brw_out  <= 1'b0;
      zero     <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= 1'b1;
        diff     <= full_diff;
        brw_out  <= hi_b[HW];
        zero     <= (full_diff == '0);
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bla_subtractor_8bit_pipe.sv
// Scoreboard bench for the pipelined borrow-lookahead subtractor.
module tb_bla_subtractor_8bit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] ain;
  logic [7:0] bin;
  logic       brw_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       brw_out;
  logic       zero;

  bla_subtractor_8bit_pipe #(.SPLIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .bin       (bin),
    .brw_in    (brw_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .brw_out   (brw_out),
    .zero      (zero)
  );

  typedef struct packed {
    logic [7:0]  d;
    logic        br;
    logic        z;
    logic        lat;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          push_cnt = 0;
  int          pop_cnt = 0;
  logic [31:0] cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Drive one beat until it is accepted; orr_mode 0=low 1=high 2=random.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input bit use_model, input logic [7:0] ed, input logic eb,
                      input logic ez, input int orr_mode, input bit lat);
    exp_t e;
    logic [8:0] r;
    bit done;
    done = 0;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      ain       = a;
      bin       = b;
      brw_in    = c;
      out_ready = (orr_mode == 2) ? 1'($urandom_range(0, 1)) : (orr_mode == 1);
      #1;
      chk("in_ready_flow", 32'(in_ready),
          32'(!(((push_cnt - pop_cnt) == 2) && !out_ready)));
      if (in_ready) begin
        if (use_model) begin
          r  = {1'b0, a} - {1'b0, b} - {8'h00, c};
          ed = r[7:0];
          eb = r[8];
          ez = (r[7:0] == 8'h00);
        end
        e.d = ed; e.br = eb; e.z = ez; e.lat = lat; e.cyc = cyc;
        sb.push_back(e);
        push_cnt++;
        done = 1;
      end
    end
    if (!done) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n, input int orr_mode);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = (orr_mode == 2) ? 1'($urandom_range(0, 1)) : (orr_mode == 1);
      #1;
      chk("in_ready_idle", 32'(in_ready),
          32'(!(((push_cnt - pop_cnt) == 2) && !out_ready)));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      idle(1, 1);
      t++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops and compares each result accepted at the coming edge.
  logic       stall;
  logic [9:0] held;
  initial begin
    exp_t e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_hold", 32'({diff, brw_out, zero}), 32'(held));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", 32'(diff), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            pop_cnt++;
            chk("diff", 32'(diff), 32'(e.d));
            chk("brw_out", 32'(brw_out), 32'(e.br));
            chk("zero", 32'(zero), 32'(e.z));
            if (e.lat) chk("latency", cyc - e.cyc, 32'd2);
          end
        end
        stall = out_valid && !out_ready;
        held  = {diff, brw_out, zero};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    ain       = 8'hA5;
    bin       = 8'h3C;
    brw_in    = 1'b1;
    out_ready = 1'b1;

    // Reset held for three cycles with a beat offered.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_diff", 32'(diff), 32'd0);
    chk("rel_brw_out", 32'(brw_out), 32'd0);
    chk("rel_zero", 32'(zero), 32'd0);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    idle(3, 1);
    chk("no_out_after_rel", 32'(out_valid), 32'd0);

    // Directed vectors with hand-computed results.
    send(8'h5A, 8'h23, 1'b0, 0, 8'h37, 1'b0, 1'b0, 1, 1);
    idle(4, 1);
    send(8'h10, 8'h01, 1'b1, 0, 8'h0E, 1'b0, 1'b0, 1, 1);
    send(8'h00, 8'h01, 1'b0, 0, 8'hFF, 1'b1, 1'b0, 1, 1);
    send(8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1, 1);
    send(8'h00, 8'h00, 1'b1, 0, 8'hFF, 1'b1, 1'b0, 1, 1);
    send(8'hFF, 8'hFF, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1, 1);
    send(8'h01, 8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b1, 1, 1);
    send(8'h0F, 8'h10, 1'b0, 0, 8'hFF, 1'b1, 1'b0, 1, 1);
    send(8'hF0, 8'h0F, 1'b1, 0, 8'hE0, 1'b0, 1'b0, 1, 1);
    drain();

    // Back-to-back streaming with no backpressure.
    for (int i = 0; i < 256; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom), 1, 8'h00, 1'b0, 1'b0, 1, 1);
    drain();

    // Random backpressure with occasional input gaps.
    for (int i = 0; i < 200; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom), 1, 8'h00, 1'b0, 1'b0, 2, 0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 2);
    end
    drain();

    // Full pipe under stall: two beats in, output held.
    send(8'h44, 8'h11, 1'b0, 0, 8'h33, 1'b0, 1'b0, 0, 0);
    send(8'h22, 8'h22, 1'b0, 0, 8'h00, 1'b0, 1'b1, 0, 0);
    idle(3, 0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drain();

    // Asynchronous reset between edges with two beats in flight.
    send(8'h9C, 8'h11, 1'b0, 0, 8'h8B, 1'b0, 1'b0, 1, 0);
    send(8'h33, 8'h44, 1'b0, 0, 8'hEF, 1'b1, 1'b0, 1, 0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    sb.delete();
    pop_cnt = push_cnt;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      idle(1, 1);
      chk("no_spurious_valid", 32'(out_valid), 32'd0);
    end
    send(8'h07, 8'h03, 1'b1, 0, 8'h03, 1'b0, 1'b0, 1, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
